act_pool_unit: RTL and testbench

Post-normalization stage that sits directly downstream of the batch-norm unit in the processing pipeline and consumes its output vectors. It applies an optional element-wise ReLU and then an optional 1-D max-pool of window 2 and stride 2 over consecutive data vectors. Results go to the write-back stage. It follows the pipeline step/clear/stall protocol, so a low `step` freezes the whole block.

---
 rtl/act_pool_pkg.sv | 30 +++
 rtl/act_pool_unit.sv | 194 +++++++++++++++++++
 tb/tb_act_pool_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/act_pool_pkg.sv
// Shared pipeline vector type for the post-normalization stages.
//   pipe_data_vect_t         : one data vector plus its side-channel fields
//   C_PIPE_DATA_VECT_RST_VAL : bubble / reset value (val=0, last=0, words 0)
package act_pool_pkg;

  localparam int unsigned C_VECT_SIZE = 4;
  localparam int unsigned C_WORD_WDT  = 16;

  typedef enum logic [1:0] {
    TYPE_DATA = 2'd0,
    TYPE_WGHT = 2'd1,
    TYPE_CFG  = 2'd2,
    TYPE_CMD  = 2'd3
  } pipe_data_type_e;

  typedef struct packed {
    logic [C_VECT_SIZE-1:0][C_WORD_WDT-1:0] data_vect_words;
    logic                                   data_vect_val;
    logic                                   data_vect_last;
    pipe_data_type_e                        data_vect_type;
  } pipe_data_vect_t;

  localparam pipe_data_vect_t C_PIPE_DATA_VECT_RST_VAL = '{
    data_vect_words: '0,
    data_vect_val:   1'b0,
    data_vect_last:  1'b0,
    data_vect_type:  TYPE_DATA
  };

endpackage

// File: rtl/act_pool_unit.sv
// Activation + pooling stage behind the batch-norm unit.
// Optional element-wise ReLU (stage 1), then optional 1-D max-pool with window 2 / stride 2
// over consecutive vectors (stage 2), result registered towards write-back.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   step, clear   : pipeline enable and synchronous flush; stall = !step
//   act_en        : ReLU enable, sampled with each input vector
//   pool_en       : pool enable, sampled with each input vector
//   data_in       : input vector (only val=1 with TYPE_DATA is accepted)
//   data_out      : registered output vector
//   out_cnt       : vectors emitted in the current tensor, modulo 2^16
module act_pool_unit
  import act_pool_pkg::*;
#(
  // Must match C_VECT_SIZE / C_WORD_WDT, which size the pipeline vector type.
  parameter int unsigned VECT_SIZE = C_VECT_SIZE,
  parameter int unsigned WORD_WDT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic            clear,
  output logic            stall,
  input  logic            act_en,
  input  logic            pool_en,
  input  pipe_data_vect_t data_in,
  output pipe_data_vect_t data_out,
  output logic [15:0]     out_cnt
);

  typedef logic [VECT_SIZE-1:0][WORD_WDT-1:0] words_t;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } pool_state_e;

  // ---------------------------------------------------------------------------
  // Stage 1: input acceptance and ReLU
  // ---------------------------------------------------------------------------
  pipe_data_vect_t s1_d, s1_q;
  logic            s1_pool_d, s1_pool_q;
  logic            in_acc;

  assign in_acc = data_in.data_vect_val && (data_in.data_vect_type == TYPE_DATA);

  always_comb begin
    s1_d      = C_PIPE_DATA_VECT_RST_VAL;
    s1_pool_d = 1'b0;
    if (in_acc) begin
      s1_d.data_vect_val  = 1'b1;
      s1_d.data_vect_last = data_in.data_vect_last;
      s1_d.data_vect_type = data_in.data_vect_type;
      s1_pool_d           = pool_en;
      for (int i = 0; i < VECT_SIZE; i++) begin
        // Negative words clamp to zero; everything else passes bit-exact.
        if (act_en && data_in.data_vect_words[i][WORD_WDT-1]) begin
          s1_d.data_vect_words[i] = '0;
        end else begin
          s1_d.data_vect_words[i] = data_in.data_vect_words[i];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: pool FSM, hold register, output register and vector counter
  // ---------------------------------------------------------------------------
  pool_state_e     state_d, state_q;
  words_t          hold_d, hold_q;
  logic            hold_vld_d, hold_vld_q;
  pipe_data_vect_t out_d, out_q;
  logic [15:0]     cnt_d, cnt_q;
  words_t          max_words;
  logic            last_out;

  // Element-wise signed max; a tie keeps the hold word.
  always_comb begin
    max_words = '0;
    for (int i = 0; i < VECT_SIZE; i++) begin
      if ($signed(s1_q.data_vect_words[i]) > $signed(hold_q[i])) begin
        max_words[i] = s1_q.data_vect_words[i];
      end else begin
        max_words[i] = hold_q[i];
      end
    end
  end

  assign last_out = out_q.data_vect_val && out_q.data_vect_last;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    out_d      = C_PIPE_DATA_VECT_RST_VAL;

    unique case (state_q)
      StIdle: begin
        if (s1_q.data_vect_val) begin
          if (s1_pool_q && !s1_q.data_vect_last) begin
            // First of a pair: park it, emit nothing this step.
            hold_d     = s1_q.data_vect_words;
            hold_vld_d = 1'b1;
            state_d    = StHold;
          end else begin
            // Bypass, or an odd tail vector emitted on its own.
            out_d = s1_q;
          end
        end
      end
      StHold: begin
        if (s1_q.data_vect_val) begin
          state_d    = StIdle;
          hold_vld_d = 1'b0;
          out_d      = s1_q;
          // pool_en dropping here is illegal: the held vector is discarded
          // and the new one bypasses.
          if (s1_pool_q) begin
            out_d.data_vect_words = max_words;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        hold_vld_d = 1'b0;
      end
    endcase

    // A tensor's last output restarts the count on the following step.
    cnt_d = cnt_q;
    if (last_out) begin
      cnt_d = '0;
    end else if (out_d.data_vect_val) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= C_PIPE_DATA_VECT_RST_VAL;
      s1_pool_q  <= 1'b0;
      state_q    <= StIdle;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      out_q      <= C_PIPE_DATA_VECT_RST_VAL;
      cnt_q      <= '0;
    end else if (step) begin
      if (clear) begin
        s1_q       <= C_PIPE_DATA_VECT_RST_VAL;
        s1_pool_q  <= 1'b0;
        state_q    <= StIdle;
        hold_q     <= '0;
        hold_vld_q <= 1'b0;
        out_q      <= C_PIPE_DATA_VECT_RST_VAL;
        cnt_q      <= '0;
      end else begin
        s1_q       <= s1_d;
        s1_pool_q  <= s1_pool_d;
        state_q    <= state_d;
        hold_q     <= hold_d;
        hold_vld_q <= hold_vld_d;
        out_q      <= out_d;
        cnt_q      <= cnt_d;
      end
    end
  end

  assign data_out = out_q;
  assign out_cnt  = cnt_q;
  assign stall    = !step;

  // ---------------------------------------------------------------------------
  // Simulation checks
  // ---------------------------------------------------------------------------
  a_in_type_data: assert property (@(posedge clk) disable iff (rst)
    !(step && data_in.data_vect_val && (data_in.data_vect_type != TYPE_DATA)));

  a_pool_drop_in_hold: assert property (@(posedge clk) disable iff (rst)
    !(step && (state_q == StHold) && s1_q.data_vect_val && !s1_pool_q));

  a_hold_vld_state: assert property (@(posedge clk) disable iff (rst)
    hold_vld_q == (state_q == StHold));

  a_out_bubble_clean: assert property (@(posedge clk) disable iff (rst)
    !out_q.data_vect_val |-> (!out_q.data_vect_last && (out_q.data_vect_words == '0)));

  a_out_type_data: assert property (@(posedge clk) disable iff (rst)
    out_q.data_vect_val |-> (out_q.data_vect_type == TYPE_DATA));

  // Every last marker leaves the FSM in IDLE, so two can never share one pairing.
  a_last_idle: assert property (@(posedge clk) disable iff (rst)
    last_out |-> (state_q == StIdle));

endmodule

// File: tb/tb_act_pool_unit.sv
module tb_act_pool_unit;
  import act_pool_pkg::*;

  typedef logic [C_VECT_SIZE-1:0][C_WORD_WDT-1:0] words_t;

  typedef struct {
    logic   act;
    logic   pool;
    words_t in_w;
    words_t exp_w;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            step;
  logic            clear;
  logic            stall;
  logic            act_en;
  logic            pool_en;
  pipe_data_vect_t data_in;
  pipe_data_vect_t data_out;
  logic [15:0]     out_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  act_pool_unit dut (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .clear    (clear),
    .stall    (stall),
    .act_en   (act_en),
    .pool_en  (pool_en),
    .data_in  (data_in),
    .data_out (data_out),
    .out_cnt  (out_cnt)
  );

  function automatic words_t mkw(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [15:0] d);
    words_t w;
    w[0] = a;
    w[1] = b;
    w[2] = c;
    w[3] = d;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the edge. stall is checked every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    check("stall", 64'(stall), 64'(!step));
  endtask

  task automatic drive(input logic v, input logic last, input words_t w);
    data_in.data_vect_val   = v;
    data_in.data_vect_last  = last;
    data_in.data_vect_words = w;
    data_in.data_vect_type  = TYPE_DATA;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic check_out(input string name, input logic val, input logic last,
                           input words_t w, input logic [15:0] cnt);
    check({name, ".val"}, 64'(data_out.data_vect_val), 64'(val));
    check({name, ".last"}, 64'(data_out.data_vect_last), 64'(last));
    check({name, ".words"}, data_out.data_vect_words, w);
    check({name, ".cnt"}, 64'(out_cnt), 64'(cnt));
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{act: 1'b1, pool: 1'b0, in_w: mkw(16'hFFFB, 16'h0003, 16'h8000, 16'h7FFF),
               exp_w: mkw(16'h0000, 16'h0003, 16'h0000, 16'h7FFF)};
    tbl[1] = '{act: 1'b0, pool: 1'b0, in_w: mkw(16'hFFFB, 16'h0003, 16'h8000, 16'h7FFF),
               exp_w: mkw(16'hFFFB, 16'h0003, 16'h8000, 16'h7FFF)};
    tbl[2] = '{act: 1'b1, pool: 1'b0, in_w: mkw(16'hFFFF, 16'h0001, 16'h7FFF, 16'h0000),
               exp_w: mkw(16'h0000, 16'h0001, 16'h7FFF, 16'h0000)};
    tbl[3] = '{act: 1'b0, pool: 1'b1, in_w: mkw(16'h1234, 16'h8001, 16'h0000, 16'hFFFF),
               exp_w: mkw(16'h1234, 16'h8001, 16'h0000, 16'hFFFF)};
    tbl[4] = '{act: 1'b1, pool: 1'b1, in_w: mkw(16'h8001, 16'h0005, 16'hC000, 16'h4000),
               exp_w: mkw(16'h0000, 16'h0005, 16'h0000, 16'h4000)};

    rst     = 1'b1;
    step    = 1'b1;
    clear   = 1'b0;
    act_en  = 1'b0;
    pool_en = 1'b0;
    drive(1'b1, 1'b1, mkw(16'h0001, 16'h0002, 16'h0003, 16'h0004));

    // Reset with valid data driven in.
    repeat (3) begin
      tick();
      check("rst.val", 64'(data_out.data_vect_val), 64'd0);
      check("rst.cnt", 64'(out_cnt), 64'd0);
    end
    rst = 1'b0;
    tick();
    check("rst_rel.s1", 64'(data_out.data_vect_val), 64'd0);
    idle();
    tick();
    check_out("rst_rel.out", 1'b1, 1'b1, mkw(16'h0001, 16'h0002, 16'h0003, 16'h0004), 16'd1);
    tick();
    check_out("rst_rel.after", 1'b0, 1'b0, '0, 16'd0);

    // Single-vector table: bypass and odd-tail, all marked last.
    for (int k = 0; k < 5; k++) begin
      act_en  = tbl[k].act;
      pool_en = tbl[k].pool;
      drive(1'b1, 1'b1, tbl[k].in_w);
      tick();
      check("tbl.s1", 64'(data_out.data_vect_val), 64'd0);
      idle();
      tick();
      check_out($sformatf("tbl%0d", k), 1'b1, 1'b1, tbl[k].exp_w, 16'd1);
      tick();
      check_out($sformatf("tbl%0d.after", k), 1'b0, 1'b0, '0, 16'd0);
    end

    // Pool pair A={-2,7}, B={-1,7,last} -> {-1,7} last.
    act_en  = 1'b0;
    pool_en = 1'b1;
    drive(1'b1, 1'b0, mkw(16'hFFFE, 16'h0007, 16'h0000, 16'h0000));
    tick();
    drive(1'b1, 1'b1, mkw(16'hFFFF, 16'h0007, 16'h0000, 16'h0000));
    tick();
    check_out("pair.a_held", 1'b0, 1'b0, '0, 16'd0);
    idle();
    tick();
    check_out("pair.out", 1'b1, 1'b1, mkw(16'hFFFF, 16'h0007, 16'h0000, 16'h0000), 16'd1);
    tick();
    check_out("pair.after", 1'b0, 1'b0, '0, 16'd0);

    // Odd tail: three vectors back to back, third is last.
    drive(1'b1, 1'b0, mkw(16'h0005, 16'hFFFD, 16'h0064, 16'h7FFF));
    tick();
    drive(1'b1, 1'b0, mkw(16'h0002, 16'hFFFF, 16'h8000, 16'h7FFE));
    tick();
    check("tail.v1_held", 64'(data_out.data_vect_val), 64'd0);
    drive(1'b1, 1'b1, mkw(16'h0009, 16'h0009, 16'h0009, 16'h0009));
    tick();
    check_out("tail.max", 1'b1, 1'b0, mkw(16'h0005, 16'hFFFF, 16'h0064, 16'h7FFF), 16'd1);
    idle();
    tick();
    check_out("tail.v3", 1'b1, 1'b1, mkw(16'h0009, 16'h0009, 16'h0009, 16'h0009), 16'd2);
    tick();
    check_out("tail.after", 1'b0, 1'b0, '0, 16'd0);

    // Stall and bubbles between A and B; inputs offered while stalled must be ignored.
    drive(1'b1, 1'b0, mkw(16'hFFFE, 16'h0007, 16'h0000, 16'h0000));
    tick();
    idle();
    tick();
    step = 1'b0;
    drive(1'b1, 1'b1, mkw(16'h7000, 16'h7000, 16'h7000, 16'h7000));
    repeat (4) begin
      tick();
      check_out("stall.frozen", 1'b0, 1'b0, '0, 16'd0);
    end
    step = 1'b1;
    idle();
    tick();
    tick();
    drive(1'b1, 1'b1, mkw(16'hFFFF, 16'h0007, 16'h0000, 16'h0000));
    tick();
    check("stall.b_s1", 64'(data_out.data_vect_val), 64'd0);
    idle();
    tick();
    check_out("stall.out", 1'b1, 1'b1, mkw(16'hFFFF, 16'h0007, 16'h0000, 16'h0000), 16'd1);
    step = 1'b0;
    tick();
    check_out("stall.out_hold", 1'b1, 1'b1, mkw(16'hFFFF, 16'h0007, 16'h0000, 16'h0000),
              16'd1);
    step = 1'b1;
    tick();
    check_out("stall.after", 1'b0, 1'b0, '0, 16'd0);

    // Clear while A is held: A must be lost, C/D pair normally.
    drive(1'b1, 1'b0, mkw(16'hFFFE, 16'h0007, 16'h0000, 16'h0000));
    tick();
    idle();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_out("clr.pulse", 1'b0, 1'b0, '0, 16'd0);
    drive(1'b1, 1'b0, mkw(16'h0004, 16'h0004, 16'h0000, 16'h0000));
    tick();
    drive(1'b1, 1'b1, mkw(16'h0001, 16'h0009, 16'h0000, 16'h0000));
    tick();
    check_out("clr.c_held", 1'b0, 1'b0, '0, 16'd0);
    idle();
    tick();
    check_out("clr.out", 1'b1, 1'b1, mkw(16'h0004, 16'h0009, 16'h0000, 16'h0000), 16'd1);
    tick();
    check_out("clr.after", 1'b0, 1'b0, '0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
